// File: rtl/alu_uart_if_pkg.sv
// alu_uart_if_pkg: FSM state encoding and ALU opcode constants shared by the UART/ALU bridge.
package alu_uart_if_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_FLG = 3'd6,
    WAIT_FLG = 3'd7
  } state_t;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;
endpackage

// File: rtl/alu_uart_if.sv
// alu_uart_if: collects A, B, opcode bytes from a UART RX, runs an external ALU, sends the result back.
// Define ALU_UART_IF_FLAGS_EN to also send a {carry, zero} flag byte after the result.
module alu_uart_if
  import alu_uart_if_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);
  state_t             r_state, w_next;
  logic [NB_DATA-1:0] r_data_a, r_data_b, r_tx_data;
  logic [NB_OP-1:0]   r_op;
`ifdef ALU_UART_IF_FLAGS_EN
  logic               r_carry, r_zero;
`else
  logic               w_unused_flags;
  assign w_unused_flags = i_alu_carry ^ i_alu_zero;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = i_rx_done ? GET_B : IDLE;
      GET_B:    w_next = i_rx_done ? GET_OP : GET_B;
      GET_OP:   w_next = i_rx_done ? EXEC : GET_OP;
      EXEC:     w_next = SEND_RES;
      SEND_RES: w_next = WAIT_RES;
`ifdef ALU_UART_IF_FLAGS_EN
      WAIT_RES: w_next = i_tx_done ? SEND_FLG : WAIT_RES;
      SEND_FLG: w_next = WAIT_FLG;
      WAIT_FLG: w_next = i_tx_done ? IDLE : WAIT_FLG;
`else
      WAIT_RES: w_next = i_tx_done ? IDLE : WAIT_RES;
`endif
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_op      <= '0;
      r_tx_data <= '0;
`ifdef ALU_UART_IF_FLAGS_EN
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_rx_done) r_data_a <= i_rx_data;
      if (r_state == GET_B && i_rx_done) r_data_b <= i_rx_data;
      if (r_state == GET_OP && i_rx_done) r_op <= i_rx_data[NB_OP-1:0];
      if (r_state == EXEC) r_tx_data <= i_alu_result;
`ifdef ALU_UART_IF_FLAGS_EN
      if (r_state == EXEC) begin
        r_carry <= i_alu_carry;
        r_zero  <= i_alu_zero;
      end
      // flag byte is staged here so it is already on o_tx_data during SEND_FLG
      if (r_state == WAIT_RES && i_tx_done)
        r_tx_data <= {{(NB_DATA-2){1'b0}}, r_carry, r_zero};
`endif
    end
  end
`ifdef ALU_UART_IF_FLAGS_EN
  assign o_tx_start = (r_state == SEND_RES) || (r_state == SEND_FLG);
`else
  assign o_tx_start = (r_state == SEND_RES);
`endif
  assign o_busy    = (r_state != IDLE);
  assign o_data_a  = r_data_a;
  assign o_data_b  = r_data_b;
  assign o_op      = r_op;
  assign o_tx_data = r_tx_data;
endmodule
